// File: rtl/key_pkg.sv
// Shared types and 50 MHz default timing for the push-button conditioner.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEB_PRESS = 3'd1,
        HOLD      = 3'd2,
        REPEAT    = 3'd3,
        DEB_REL   = 3'd4
    } key_state_e;

    localparam int DEF_DEBOUNCE_CYC = 1_000_000;
    localparam int DEF_HOLD_CYC     = 25_000_000;
    localparam int DEF_REPEAT_CYC   = 5_000_000;
    localparam int DEF_CNT_W        = 25;

endpackage

// File: rtl/key_channel.sv
// One push-button channel: 2-flop synchroniser, press/release debounce FSM and
// press pulse; auto-repeat is built only when KEY_AUTOREPEAT_EN is defined.
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int HOLD_CYC     = DEF_HOLD_CYC,
    parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic pulse_o,
    output logic held_o
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
`endif

    logic [1:0]       sync_q, sync_d;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             held_q, held_d;
    logic             s;

    // Second synchroniser stage, inverted so that 1 means pressed.
    assign s = ~sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], key_n_i};
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (s) state_d = DEB_PRESS;
            end
            DEB_PRESS: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HOLD;
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                end
            end
`ifdef KEY_AUTOREPEAT_EN
            HOLD: begin
                if (!s) begin
                    state_d = DEB_REL;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = REPEAT;
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            REPEAT: begin
                if (!s) begin
                    state_d = DEB_REL;
                    cnt_d   = '0;
                end else if (cnt_q == REP_LAST) begin
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                end
            end
`else
            HOLD: begin
                cnt_d = '0;
                if (!s) state_d = DEB_REL;
            end
`endif
            DEB_REL: begin
                // A bounce back to pressed re-enters HOLD and restarts the repeat timing.
                if (s) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d == HOLD) || (state_d == REPEAT) || (state_d == DEB_REL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            held_q  <= held_d;
        end
    end

    assign pulse_o = pulse_q;
    assign held_o  = held_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions N_KEYS active-low buttons and blocks pulses while keys overlap.
// Auto-repeat in each channel is enabled by defining KEY_AUTOREPEAT_EN.
module key_conditioner
    import key_pkg::*;
#(
    parameter int N_KEYS       = 2,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int HOLD_CYC     = DEF_HOLD_CYC,
    parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n_i,
    output logic [N_KEYS-1:0] pulse_o,
    output logic [N_KEYS-1:0] held_o,
    output logic              lockout_o
);

    logic [N_KEYS-1:0] ch_pulse;
    logic [N_KEYS-1:0] ch_held;
    logic [N_KEYS-1:0] others_held;

    logic [N_KEYS-1:0] pulse_q, pulse_d;
    logic [N_KEYS-1:0] held_q, held_d;
    logic              lockout_q, lockout_d;

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_ch
            localparam logic [N_KEYS-1:0] SELF = N_KEYS'(1) << gi;

            key_channel #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC),
                .HOLD_CYC     (HOLD_CYC),
                .REPEAT_CYC   (REPEAT_CYC),
                .CNT_W        (CNT_W)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .key_n_i (key_n_i[gi]),
                .pulse_o (ch_pulse[gi]),
                .held_o  (ch_held[gi])
            );

            assign others_held[gi] = |(ch_held & ~SELF);
        end
    endgenerate

    // Pulses that coincide with another held key are dropped outright.
    always_comb begin
        pulse_d   = ch_pulse & ~others_held;
        held_d    = ch_held;
        lockout_d = ($countones(ch_held) > 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q   <= '0;
            held_q    <= '0;
            lockout_q <= 1'b0;
        end else begin
            pulse_q   <= pulse_d;
            held_q    <= held_d;
            lockout_q <= lockout_d;
        end
    end

    assign pulse_o   = pulse_q;
    assign held_o    = held_q;
    assign lockout_o = lockout_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: reset/press vector table, directed corner
// sequences and random key activity, all checked against a run-length model.
module tb_key_conditioner;

    localparam int D = 4;
    localparam int H = 10;
    localparam int R = 3;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] key_n_i = 2'b11;
    logic [1:0] pulse_o;
    logic [1:0] held_o;
    logic       lockout_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    key_conditioner #(
        .N_KEYS       (2),
        .DEBOUNCE_CYC (D),
        .HOLD_CYC     (H),
        .REPEAT_CYC   (R),
        .CNT_W        (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_n_i   (key_n_i),
        .pulse_o   (pulse_o),
        .held_o    (held_o),
        .lockout_o (lockout_o)
    );

    // Reference model: keys described by run lengths of the synchronised level.
    logic       m_sync1 [2];
    logic       m_sync2 [2];
    bit         m_down  [2];
    bit         m_rel   [2];
    int         m_run_p [2];
    int         m_run_z [2];
    int         m_hold_t[2];
    logic [1:0] m_chp, m_chh;
    logic [1:0] exp_p, exp_h;
    logic       exp_l;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sync1[k] = 1'b1; m_sync2[k] = 1'b1;
            m_down[k] = 0; m_rel[k] = 0;
            m_run_p[k] = 0; m_run_z[k] = 0; m_hold_t[k] = 0;
        end
        m_chp = 2'b00; m_chh = 2'b00;
        exp_p = 2'b00; exp_h = 2'b00; exp_l = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic [1:0] kn);
        logic s;
        if (r) begin
            model_reset();
            return;
        end
        exp_p = 2'b00;
        for (int k = 0; k < 2; k++)
            exp_p[k] = m_chp[k] && !m_chh[1-k];
        exp_h = m_chh;
        exp_l = m_chh[0] && m_chh[1];
        for (int k = 0; k < 2; k++) begin
            s = ~m_sync2[k];
            m_chp[k] = 1'b0;
            if (!m_down[k]) begin
                m_run_p[k] = s ? m_run_p[k] + 1 : 0;
                if (m_run_p[k] == D + 1) begin
                    m_down[k] = 1; m_rel[k] = 0; m_hold_t[k] = 0; m_run_p[k] = 0;
                    m_chp[k] = 1'b1;
                end
            end else if (!m_rel[k]) begin
                if (s) begin
                    m_hold_t[k]++;
                    if (AR && (m_hold_t[k] == H ||
                               (m_hold_t[k] > H && (m_hold_t[k] - H) % R == 0)))
                        m_chp[k] = 1'b1;
                end else begin
                    m_rel[k] = 1; m_run_z[k] = 1;
                end
            end else begin
                if (s) begin
                    m_rel[k] = 0; m_hold_t[k] = 0;
                end else begin
                    m_run_z[k]++;
                    if (m_run_z[k] == D + 1) begin
                        m_down[k] = 0; m_rel[k] = 0; m_run_p[k] = 0;
                    end
                end
            end
            m_chh[k] = m_down[k];
        end
        for (int k = 0; k < 2; k++) begin
            m_sync2[k] = m_sync1[k];
            m_sync1[k] = kn[k];
        end
    endtask

    task automatic check3(input string name, input logic [1:0] ep, input logic [1:0] eh,
                          input logic el);
        n_cmp++;
        if (pulse_o !== ep || held_o !== eh || lockout_o !== el) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got pulse=%b held=%b lock=%b, want pulse=%b held=%b lock=%b",
                     name, cyc, pulse_o, held_o, lockout_o, ep, eh, el);
        end
    endtask

    // One clock: drive on the falling edge, advance the model on the rising edge, check 1 ns later.
    task automatic cycle(input string name, input logic r, input logic [1:0] kn);
        @(negedge clk);
        rst = r;
        key_n_i = kn;
        @(posedge clk);
        cyc++;
        model_step(r, kn);
        #1;
        check3(name, exp_p, exp_h, exp_l);
    endtask

    task automatic run(input string name, input logic [1:0] kn, input int n);
        for (int i = 0; i < n; i++) cycle(name, 1'b0, kn);
        $display("seq %-10s key_n=%b x%0d done at cyc %0d", name, kn, n, cyc);
    endtask

    typedef struct {
        logic       r;
        logic [1:0] kn;
        logic [1:0] ep;
        logic [1:0] eh;
        logic       el;
    } vec_t;

    vec_t tbl[24];
    int   e;
    int   pulses;
    logic [1:0] rk;
    int   rem[2];

    initial begin
        for (int i = 0; i < 24; i++) begin
            if (i < 3) begin
                tbl[i] = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0};
            end else begin
                e = i - 3;
                tbl[i].r  = 1'b0;
                tbl[i].kn = 2'b10;
                tbl[i].ep = (e == 7 || (AR && (e == 17 || e == 20))) ? 2'b01 : 2'b00;
                tbl[i].eh = (e >= 7) ? 2'b01 : 2'b00;
                tbl[i].el = 1'b0;
            end
        end
        model_reset();

        // Reset with both keys pressed, then key 0 held from the first released-reset edge.
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            rst = tbl[i].r;
            key_n_i = tbl[i].kn;
            @(posedge clk);
            cyc++;
            model_step(tbl[i].r, tbl[i].kn);
            #1;
            check3("table", tbl[i].ep, tbl[i].eh, tbl[i].el);
            $display("vec %0d rst=%b key_n=%b pulse=%b held=%b lock=%b", i, tbl[i].r,
                     tbl[i].kn, pulse_o, held_o, lockout_o);
        end
        run("release", 2'b11, 15);

        // Press bounce: toggle every two cycles, then stable low.
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cycle("bounce", 1'b0, ((i / 2) % 2 == 0) ? 2'b10 : 2'b11);
            pulses += pulse_o[0];
        end
        for (int i = 0; i < 12; i++) begin
            cycle("bounce", 1'b0, 2'b10);
            pulses += pulse_o[0];
        end
        n_cmp++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL bounce_count: got %0d pulses, want 1", pulses);
        end
        run("release", 2'b11, 15);

        run("autorep", 2'b10, 50);
        run("release", 2'b11, 15);

        // Release bounce after a press.
        run("press", 2'b10, 12);
        for (int i = 0; i < 12; i++)
            cycle("relbounce", 1'b0, ((i / 2) % 2 == 0) ? 2'b11 : 2'b10);
        run("relbounce", 2'b11, 15);

        // Lockout: key 1 held, key 0 joins, key 1 leaves.
        run("lock_k1", 2'b01, 10);
        run("lock_both", 2'b00, 30);
        run("lock_k0", 2'b10, 30);
        run("release", 2'b11, 15);

        // Reset during auto-repeat clears outputs immediately.
        run("midhold", 2'b10, 30);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check3("async_rst", 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) cycle("in_rst", 1'b1, 2'b10);
        run("after_rst", 2'b10, 14);
        run("release", 2'b11, 15);

        // Random key activity with occasional resets.
        rk = 2'b11;
        rem[0] = 0; rem[1] = 0;
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (rem[k] == 0) begin
                    rk[k] = 1'($urandom_range(0, 1));
                    rem[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                         : $urandom_range(4, 30);
                end
                rem[k]--;
            end
            cycle("random", ($urandom_range(0, 299) == 0), rk);
        end
        $display("seq random     800 cycles done at cyc %0d", cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
